// File: rtl/led_pwm_fader_pkg.sv
// Shared types and arithmetic helpers for the LED PWM fader.
// Helpers work at a fixed 17-bit width, which covers PWM_BITS up to 16 without wrap.
package led_pwm_fader_pkg;

    localparam int LED_COUNT  = 8;
    localparam int LEVEL_BITS = 8;
    localparam int CALC_W     = 17;

    typedef logic [LEVEL_BITS-1:0] level_t;
    typedef logic [CALC_W-1:0]     calc_t;

    function automatic calc_t sat_step_up(input calc_t level, input calc_t step, input calc_t target);
        calc_t sum;
        sum = level + step;
        return (sum > target) ? target : sum;
    endfunction

    function automatic calc_t sat_step_down(input calc_t level, input calc_t step, input calc_t target);
        return (level > target + step) ? (level - step) : target;
    endfunction

    // Squared-law duty; full scale is pinned so a fully lit LED stays solidly on.
    function automatic calc_t gamma_duty(input calc_t level, input int bits);
        logic [2*CALC_W-1:0] sq;
        calc_t               max_level;
        max_level = calc_t'((1 << bits) - 1);
        sq        = {{CALC_W{1'b0}}, level} * {{CALC_W{1'b0}}, level};
        if (level == max_level) begin
            return max_level;
        end
        return calc_t'(sq >> bits);
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED: level register fading toward its target, period-aligned shadow duty and PWM compare.
// Optional LED_PWM_FADER_GAMMA_EN selects a squared-law duty curve instead of linear.
module led_fade_channel
    import led_pwm_fader_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int FADE_STEP = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_pattern,
    input  logic [PWM_BITS-1:0] i_brightness,
    input  logic [PWM_BITS-1:0] i_counter,
    input  logic                i_step_tick,
    input  logic                i_boundary,
    output logic                o_led,
    output logic                o_mismatch
);

    localparam calc_t STEP = calc_t'(FADE_STEP);

    logic [PWM_BITS-1:0] r_level;
    logic [PWM_BITS-1:0] r_shadow;
    logic                r_led;
    logic [PWM_BITS-1:0] w_target;
    logic [PWM_BITS-1:0] w_level_next;
    logic [PWM_BITS-1:0] w_duty;

    assign w_target = i_pattern ? i_brightness : '0;

    always_comb begin
        w_level_next = r_level;
        if (r_level < w_target) begin
            w_level_next = PWM_BITS'(sat_step_up(calc_t'(r_level), STEP, calc_t'(w_target)));
        end else if (r_level > w_target) begin
            w_level_next = PWM_BITS'(sat_step_down(calc_t'(r_level), STEP, calc_t'(w_target)));
        end
    end

`ifdef LED_PWM_FADER_GAMMA_EN
    assign w_duty = PWM_BITS'(gamma_duty(calc_t'(r_level), PWM_BITS));
`else
    assign w_duty = r_level;
`endif

    // Shadow samples the pre-tick level when a step and a boundary coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level  <= '0;
            r_shadow <= '0;
            r_led    <= 1'b0;
        end else begin
            if (i_step_tick) begin
                r_level <= w_level_next;
            end
            if (i_boundary) begin
                r_shadow <= w_duty;
            end
            r_led <= (r_shadow > i_counter);
        end
    end

    assign o_led      = r_led;
    assign o_mismatch = (r_level != w_target);

endmodule

// File: rtl/led_pwm_fader.sv
// LED fader top: fade step divider, shared PWM counter, busy flag and eight fade channels.
// Optional LED_PWM_FADER_GAMMA_EN (see led_fade_channel) changes the duty curve only.
module led_pwm_fader
    import led_pwm_fader_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int STEP_DIV  = 50000,
    parameter int FADE_STEP = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LED_COUNT-1:0] pattern_in,
    input  logic [PWM_BITS-1:0]  brightness,
    output logic [LED_COUNT-1:0] led_out,
    output logic                 busy
);

    localparam int                 DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(STEP_DIV - 1);
    // Period is 2^PWM_BITS-1 so a full-scale duty keeps the LED on every cycle.
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

    logic [DIV_W-1:0]     r_div_cnt;
    logic [PWM_BITS-1:0]  r_pwm_cnt;
    logic                 r_busy;
    logic                 w_step_tick;
    logic                 w_boundary;
    logic [LED_COUNT-1:0] w_led;
    logic [LED_COUNT-1:0] w_mismatch;

    assign w_step_tick = (r_div_cnt == DIV_LAST);
    assign w_boundary  = (r_pwm_cnt == PWM_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_pwm_cnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_div_cnt <= w_step_tick ? '0 : r_div_cnt + 1'b1;
            r_pwm_cnt <= w_boundary  ? '0 : r_pwm_cnt + 1'b1;
            r_busy    <= |w_mismatch;
        end
    end

    generate
        for (genvar gi = 0; gi < LED_COUNT; gi++) begin : g_chan
            led_fade_channel #(
                .PWM_BITS  (PWM_BITS),
                .FADE_STEP (FADE_STEP)
            ) u_chan (
                .clk          (clk),
                .reset        (reset),
                .i_pattern    (pattern_in[gi]),
                .i_brightness (brightness),
                .i_counter    (r_pwm_cnt),
                .i_step_tick  (w_step_tick),
                .i_boundary   (w_boundary),
                .o_led        (w_led[gi]),
                .o_mismatch   (w_mismatch[gi])
            );
        end
    endgenerate

    assign led_out = w_led;
    assign busy    = r_busy;

endmodule
